// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave (and the matching master).
// Contents: FSM state type and default word width / synchronizer depth.
package spi_pkg;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic {
    StIdle,
    StShift
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Local-side word interface of the SPI slave.
// Signals:
//   tx_data/tx_valid  -> slave : next word to transmit
//   tx_ready          <- slave : holding register empty
//   rx_data/rx_valid  <- slave : received word and one-cycle strobe
//   busy              <- slave : frame in progress
//   tx_underrun       <- slave : word started with empty holding register
// Modports: slave (the SPI slave), master (the local logic driving it).
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              tx_underrun;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output busy,
    output tx_underrun
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  tx_underrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus edge detector.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_async    : asynchronous input
//   o_level    : synchronized level
//   o_rise     : one-cycle pulse on synchronized 0->1
//   o_fall     : one-cycle pulse on synchronized 1->0
// RESET_VAL sets the idle level so no false edge is seen out of reset.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave, oversampled on the system clock.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   i_sclk/i_ss_n/i_mosi : asynchronous SPI bus inputs
//   o_miso, o_miso_oe : serial output and tristate enable (1 while selected)
//   bus (slave)       : TX holding handshake, RX word strobe, busy, underrun
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first bit order in both
// directions; otherwise words are shifted MSB first.
// sclk high/low phases must each last at least SYNC_STAGES+2 clk cycles.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sclk,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  spi_slave_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_sclk),
    .o_level(w_sclk_level),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_ss_n),
    .o_level(w_ss_level),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_mosi),
    .o_level(w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  spi_state_e        r_state, w_state_next;
  logic [DATA_W-1:0] r_tx_shift, r_rx_shift, r_hold, r_rx_data;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_hold_full, r_rx_valid, r_underrun;

  logic              w_word_start, w_tx_shift_en, w_rx_sample, w_frame_end;
  logic              w_busy, w_tx_bit, w_accept;
  logic [DATA_W-1:0] w_tx_shifted, w_rx_next;
  logic              w_unused;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_tx_bit     = r_tx_shift[0];
  assign w_tx_shifted = {1'b0, r_tx_shift[DATA_W-1:1]};
  assign w_rx_next    = {w_mosi, r_rx_shift[DATA_W-1:1]};
  assign w_unused     = ^{w_sclk_level, w_ss_level, w_mosi_rise, w_mosi_fall, r_rx_shift[0]};
`else
  assign w_tx_bit     = r_tx_shift[DATA_W-1];
  assign w_tx_shifted = {r_tx_shift[DATA_W-2:0], 1'b0};
  assign w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi};
  assign w_unused     = ^{w_sclk_level, w_ss_level, w_mosi_rise, w_mosi_fall,
                          r_rx_shift[DATA_W-1]};
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_ss_fall) w_state_next = StShift;
      StShift: if (w_ss_rise) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    w_word_start  = 1'b0;
    w_tx_shift_en = 1'b0;
    w_rx_sample   = 1'b0;
    w_frame_end   = 1'b0;
    w_busy        = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_word_start = w_ss_fall;
      end
      StShift: begin
        w_busy = 1'b1;
        // ss_n rising wins over any sclk edge seen in the same cycle
        if (w_ss_rise) begin
          w_frame_end = 1'b1;
        end else begin
          w_rx_sample = w_sclk_rise;
          // bit_cnt is 0 only after a completed word: that fall starts the next one
          if (w_sclk_fall) begin
            if (r_bit_cnt == '0) w_word_start  = 1'b1;
            else                 w_tx_shift_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_accept = bus.tx_valid & ~r_hold_full;

  // TX holding register; an accept coinciding with a word start bypasses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept && !w_word_start) begin
      r_hold      <= bus.tx_data;
      r_hold_full <= 1'b1;
    end else if (w_word_start && r_hold_full) begin
      r_hold_full <= 1'b0;
    end
  end

  // Shift registers, bit counter and RX word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (w_word_start) begin
        r_tx_shift <= r_hold_full ? r_hold : (w_accept ? bus.tx_data : '0);
        r_underrun <= ~r_hold_full & ~w_accept;
      end else if (w_tx_shift_en) begin
        r_tx_shift <= w_tx_shifted;
      end else if (w_frame_end) begin
        r_tx_shift <= '0;
      end

      if (w_rx_sample) begin
        r_rx_shift <= w_rx_next;
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (w_frame_end) begin
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
      end
    end
  end

  assign o_miso          = w_busy & w_tx_bit;
  assign o_miso_oe       = w_busy;
  assign bus.busy        = w_busy;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural mode-0 SPI master, directed
// vector table, hand-written abort/reset sequences and randomized frames.
module tb_spi_slave;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sclk   (sclk),
    .i_ss_n   (ss_n),
    .i_mosi   (mosi),
    .o_miso   (miso),
    .o_miso_oe(miso_oe),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int n_under = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (bus.tx_underrun) n_under++;
  end

  // master-side words and refill schedule shared by frame/refill tasks
  logic [7:0] m_tx[4];
  logic [7:0] m_rx[4];
  bit         rf_have[5];
  logic [7:0] rf_data[5];
  int         rf_n = 0;
  logic       first_miso;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int bidx(input int b);
    return LSB_FIRST ? b : 7 - b;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    logic [7:0] r;
    r = 'x;
    if (i < rx_q.size()) r = rx_q[i];
    return r;
  endfunction

  task automatic push_hold(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.tx_ready) begin
        @(negedge clk);
        bus.tx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("push_hold_timeout", 32'd1, 32'd0);
  endtask

  task automatic refill_proc(input int t0);
    for (int w = 1; w <= rf_n; w++) begin
      for (int i = 0; i < 5000 && cyc < t0 + (w - 1) * 16 * HALF + 40; i++) @(negedge clk);
      if (rf_have[w]) push_hold(rf_data[w]);
    end
  endtask

  // One ss_n frame; abort_bits>0 cuts the last word short, rst_mid asserts
  // rst_n at that point. The final sclk fall coincides with ss_n rising.
  task automatic frame(input int nw, input int abort_bits, input bit rst_mid);
    int nb;
    fork
      refill_proc(cyc);
    join_none
    ss_n = 1'b0;
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1 && abort_bits > 0) ? abort_bits : 8;
      m_rx[w] = '0;
      for (int b = 0; b < nb; b++) begin
        mosi = m_tx[w][bidx(b)];
        repeat (HALF) @(negedge clk);
        m_rx[w][bidx(b)] = miso;
        if (w == 0 && b == 0) begin
          first_miso = miso;
          check("busy_in_frame", bus.busy, 1);
          check("miso_oe_in_frame", miso_oe, 1);
        end
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        if (!(w == nw - 1 && b == nb - 1)) sclk = 1'b0;
      end
    end
    if (rst_mid) begin
      check("rst_ready_pre", bus.tx_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_rx_data", bus.rx_data, 0);
      check("rst_rx_valid", bus.rx_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_underrun", bus.tx_underrun, 0);
    end
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    if (rst_mid) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (4 * HALF) @(negedge clk);
  endtask

  typedef struct {
    bit         pre_v;
    logic [7:0] pre;
    int         nw;
    logic [7:0] mo0, mo1;
    bit         rf;
    logic [7:0] rfd;
    logic [7:0] em0, em1;
    int         eu;
    bit         chk_first;
  } vec_t;

  vec_t vecs[4];
  int   nvec;

  initial begin
    logic [7:0] exp_miso[4];
    logic [7:0] d0;
    bit         have0;
    int         nw, eu;

    vecs[0] = '{1'b1, 8'hA5, 1, 8'h3C, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h00, 0, 1'b0};
    vecs[1] = '{1'b1, 8'hAA, 2, 8'h11, 8'h22, 1'b1, 8'h55, 8'hAA, 8'h55, 0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1, 1'b0};
    nvec = 3;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    vecs[3] = '{1'b1, 8'h01, 1, 8'h80, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 0, 1'b1};
    nvec = 4;
`endif

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", miso, 0);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_tx_ready", bus.tx_ready, 1);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_underrun", bus.tx_underrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // directed vector table
    for (int v = 0; v < nvec; v++) begin
      rx_q.delete();
      n_under = 0;
      if (vecs[v].pre_v) push_hold(vecs[v].pre);
      check($sformatf("v%0d_ready_pre", v), bus.tx_ready, vecs[v].pre_v ? 0 : 1);
      m_tx[0] = vecs[v].mo0;
      m_tx[1] = vecs[v].mo1;
      rf_n = vecs[v].nw - 1;
      rf_have[1] = vecs[v].rf;
      rf_data[1] = vecs[v].rfd;
      frame(vecs[v].nw, 0, 1'b0);
      check($sformatf("v%0d_rx_count", v), rx_q.size(), vecs[v].nw);
      check($sformatf("v%0d_rx0", v), rx_at(0), vecs[v].mo0);
      check($sformatf("v%0d_miso0", v), m_rx[0], vecs[v].em0);
      if (vecs[v].nw > 1) begin
        check($sformatf("v%0d_rx1", v), rx_at(1), vecs[v].mo1);
        check($sformatf("v%0d_miso1", v), m_rx[1], vecs[v].em1);
      end
      check($sformatf("v%0d_underrun", v), n_under, vecs[v].eu);
      check($sformatf("v%0d_ready_post", v), bus.tx_ready, 1);
      check($sformatf("v%0d_busy_post", v), bus.busy, 0);
      if (vecs[v].chk_first) check($sformatf("v%0d_first_bit", v), first_miso, 1);
    end

    // partial frame: 5 bits of 0xC3 then a full 0x81
    rx_q.delete();
    m_tx[0] = 8'hC3;
    rf_n = 0;
    frame(1, 5, 1'b0);
    check("abort_no_rx", rx_q.size(), 0);
    check("abort_rx_data", bus.rx_data, vecs[nvec-1].mo0);
    check("abort_busy", bus.busy, 0);
    check("abort_miso_oe", miso_oe, 0);
    m_tx[0] = 8'h81;
    frame(1, 0, 1'b0);
    check("after_abort_count", rx_q.size(), 1);
    check("after_abort_rx", rx_at(0), 8'h81);

    // reset during the third word, then a clean 0x7E frame
    rx_q.delete();
    n_under = 0;
    m_tx[0] = 8'h5A;
    m_tx[1] = 8'h3C;
    m_tx[2] = 8'h99;
    rf_n = 3;
    rf_have[1] = 1'b1; rf_data[1] = 8'h12;
    rf_have[2] = 1'b1; rf_data[2] = 8'h34;
    rf_have[3] = 1'b1; rf_data[3] = 8'h56;
    push_hold(8'hE1);
    frame(3, 4, 1'b1);
    check("rst_frame_rx_count", rx_q.size(), 2);
    check("rst_frame_rx1", rx_at(1), 8'h3C);
    check("rst_frame_miso1", m_rx[1], 8'h12);
    rx_q.delete();
    n_under = 0;
    m_tx[0] = 8'h7E;
    rf_n = 0;
    frame(1, 0, 1'b0);
    check("post_rst_rx", rx_at(0), 8'h7E);
    check("post_rst_miso", m_rx[0], 8'h00);
    check("post_rst_underrun", n_under, 1);

    // randomized frames against a word-level model
    for (int f = 0; f < 8; f++) begin
      rx_q.delete();
      n_under = 0;
      nw = $urandom_range(1, 3);
      have0 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom);
      rf_n = nw - 1;
      for (int w = 0; w < nw; w++) m_tx[w] = 8'($urandom);
      for (int w = 1; w < nw; w++) begin
        rf_have[w] = 1'($urandom_range(0, 1));
        rf_data[w] = 8'($urandom);
      end
      eu = 0;
      for (int w = 0; w < nw; w++) begin
        if (w == 0) exp_miso[w] = have0 ? d0 : 8'h00;
        else        exp_miso[w] = rf_have[w] ? rf_data[w] : 8'h00;
        if ((w == 0 && !have0) || (w > 0 && !rf_have[w])) eu++;
      end
      if (have0) push_hold(d0);
      frame(nw, 0, 1'b0);
      check($sformatf("rnd%0d_count", f), rx_q.size(), nw);
      for (int w = 0; w < nw; w++) begin
        check($sformatf("rnd%0d_rx%0d", f, w), rx_at(w), m_tx[w]);
        check($sformatf("rnd%0d_miso%0d", f, w), m_rx[w], exp_miso[w]);
      end
      check($sformatf("rnd%0d_underrun", f), n_under, eu);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0 (CPOL=0, CPHA=0) target. It is the far end of the team's SPI master on the same bus.
- Oversamples sclk/ss_n/mosi on the system clock and drives miso.
- Exchanges DATA_W-bit words with local logic through a valid/ready TX holding register and a one-cycle rx_valid strobe.
- Multiple back-to-back words per ss_n frame are supported.

Parameters:
DATA_W, 8, word width in bits (>=2)
SYNC_STAGES, 2, synchronizer flops on sclk, ss_n, mosi (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sclk  in  1  SPI serial clock from master (async)
ss_n  in  1  SPI slave select, active low (async)
mosi  in  1  SPI master-out data (async)
miso  out  1  SPI slave-out data
miso_oe  out  1  output enable for external tristate; 1 while selected
tx_data  in  DATA_W  next word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle strobe: rx_data updated
busy  out  1  frame in progress (synchronized ss_n low)
tx_underrun  out  1  one-cycle strobe: word started with empty holding register

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0. Internal shift registers, bit counter, holding register and sync flops are all cleared. FSM goes to IDLE.
- Sync: sclk, ss_n and mosi each pass through SYNC_STAGES flops. ss_n sync flops reset to 1.
- Edge detect: one extra flop on synced sclk gives sclk_rise/sclk_fall pulses.
- Speed limit: sclk high and low phases must each be >= SYNC_STAGES+2 clk cycles. Faster sclk is unsupported.
- TX holding: accepted when tx_valid & tx_ready; tx_ready falls the next cycle. A word is consumed at word start, and tx_ready rises the cycle after consumption. A same-cycle accept and consume is allowed (bypass).
- FSM IDLE:
  - On synced ss_n falling: busy=1, miso_oe=1, go to SHIFT.
  - Word start: if holding is full, load it into tx_shift, else load 0 and pulse tx_underrun.
  - Drive miso = tx_shift MSB before the first sclk_rise.
- FSM SHIFT, per bit:
  - sclk_rise: shift the synced mosi into rx_shift (MSB first); bit_cnt++.
  - sclk_fall: if bit_cnt < DATA_W, shift tx_shift left and present the next bit on miso. The fall after the last bit is a word start (see next item).
- Word complete: the DATA_W-th sclk_rise writes rx_data <= {rx_shift, mosi_sync} and pulses rx_valid the next cycle. bit_cnt returns to 0. The following sclk_fall performs a new word start (holding or underrun, as above).
- ss_n rising (synced), any state: return to IDLE. busy=0, miso_oe=0, miso=0.
  - A partial word is discarded (no rx_valid, rx_data unchanged) and bit_cnt is cleared.
  - A word loaded into tx_shift but not fully sent is lost. The holding register is retained.
- Simultaneous events: an ss_n rise takes priority over an sclk edge in the same cycle. An sclk edge while ss_n is synced high is ignored.
- Overrun: rx_data is overwritten unconditionally; there is no back-pressure on RX.
- Async reset mid-frame returns all outputs to their reset values. Operation resumes only at the next ss_n falling edge.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN
- Defined: bit order is LSB first in both directions. rx_shift shifts right; tx_shift presents bit 0 first and shifts right.
- Undefined: MSB first, as above.
- Handshake and timing are identical in both cases.

Decomposition:
- Shared package spi_pkg: FSM state typedef (IDLE, SHIFT) and default constants DATA_W=8, SYNC_STAGES=2. The master reuses DATA_W.
- One natural sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall detector. It is instantiated for sclk (edges used), ss_n (edges used) and mosi (level only).

Test Plan:
1. Holding loaded with 0xA5, then master sends 0x3C in mode 0 with 8 clk per sclk phase -> master receives 0xA5; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1 after ss_n fall; tx_underrun stays 0.
2. Two words in one ss_n frame: master sends 0x11, 0x22; holding refilled with 0x55 during word 1 (initial 0xAA) -> miso carries 0xAA then 0x55; two rx_valid pulses with 0x11 then 0x22.
3. No tx_valid before ss_n fall, master sends 0xFF -> miso all 0; tx_underrun pulses once at frame start; rx_data=0xFF.
4. ss_n deasserted after 5 bits of 0xC3 -> no rx_valid; rx_data holds its previous value; busy=0, miso_oe=0; the next full frame of 0x81 receives 0x81 correctly.
5. rst_n asserted mid-word 3 -> all outputs at reset values within 0 clk (async). After release, a frame of 0x7E is received correctly.
6. With SPI_SLAVE_LSB_FIRST_EN, holding 0x01 and master shifts LSB first sending 0x80 -> first miso bit is 1; rx_data=0x80.
